// File: rtl/lfsr_sched_pkg.sv
// lfsr_sched_pkg: shared LFSR constants, FSM state type and LFSR update function
package lfsr_sched_pkg;

    localparam int LFSR_W = 5;
    localparam logic [LFSR_W-1:0] LFSR_RST = 5'h01;

    typedef enum logic [1:0] {IDLE, STEP, RESP} sched_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[0], s[4], s[3] ^ s[0], s[2], s[1]};
    endfunction

endpackage

// File: rtl/lfsr_sched_if.sv
// lfsr_sched_if: request, seed and response channels between clients and the scheduler
interface lfsr_sched_if #(
    parameter int NREQ = 4,
    parameter int CW = 4
);
    import lfsr_sched_pkg::*;

    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0] req_valid;
    logic [NREQ*CW-1:0] req_steps;
    logic [NREQ-1:0] req_ready;
    logic seed_valid;
    logic [LFSR_W-1:0] seed;
    logic seed_ready;
    logic rsp_valid;
    logic rsp_ready;
    logic [IW-1:0] rsp_id;
    logic [LFSR_W-1:0] rsp_data;
    logic busy;

    modport master (
        output req_valid, req_steps, seed_valid, seed, rsp_ready,
        input req_ready, seed_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input req_valid, req_steps, seed_valid, seed, rsp_ready,
        output req_ready, seed_ready, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/lfsr_step_core.sv
// lfsr_step_core: 5-bit Galois LFSR register with zero-safe seed load
module lfsr_step_core
    import lfsr_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] state
);

    // load beats step; a zero seed is replaced so the register never locks up
    always_ff @(posedge clk) begin
        if (rst)
            state <= LFSR_RST;
        else if (load)
            state <= (load_val == '0) ? LFSR_RST : load_val;
        else if (en)
            state <= lfsr_next(state);
    end

endmodule

// File: rtl/lfsr_sched.sv
// lfsr_sched: round-robin scheduler sharing one LFSR among NREQ requesters
// Optional statistics outputs are enabled with `define LFSR_SCHED_STATS_EN
module lfsr_sched
    import lfsr_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW = 4
) (
    input  logic        clk,
    input  logic        rst,
    lfsr_sched_if.slave bus
`ifdef LFSR_SCHED_STATS_EN
    ,
    output logic [15:0] stat_grants,
    output logic [15:0] stat_stalls
`endif
);

    localparam int IW = $clog2(NREQ);

    sched_state_e st;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick;
    logic any;
    logic [CW-1:0] cnt;
    logic [CW-1:0] pick_steps;
    logic [LFSR_W-1:0] lfsr;
    logic idle;
    logic load;
    logic grant;

    lfsr_step_core u_core (
        .clk(clk),
        .rst(rst),
        .en(st == STEP),
        .load(load),
        .load_val(bus.seed),
        .state(lfsr)
    );

    // round-robin pick: scan downward so the smallest offset from rr_ptr wins
    always_comb begin
        pick = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                pick = IW'((int'(rr_ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end

    assign idle = (st == IDLE);
    assign load = idle & bus.seed_valid;
    assign grant = idle & ~bus.seed_valid & any;
    assign pick_steps = bus.req_steps[int'(pick) * CW +: CW];
    assign bus.req_ready = grant ? (NREQ'(1) << pick) : '0;
    assign bus.seed_ready = idle;
    assign bus.busy = ~idle;

    // scheduler FSM; response data is captured as the post-step LFSR value
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            rr_ptr <= '0;
            cnt <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id <= '0;
            bus.rsp_data <= LFSR_RST;
        end else begin
            case (st)
                IDLE: if (grant) begin
                    bus.rsp_id <= pick;
                    cnt <= pick_steps;
                    if (pick_steps == '0) begin
                        st <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data <= lfsr;
                    end else begin
                        st <= STEP;
                    end
                end
                STEP: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        st <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data <= lfsr_next(lfsr);
                    end
                end
                RESP: if (bus.rsp_ready) begin
                    st <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    rr_ptr <= (bus.rsp_id == IW'(NREQ - 1)) ? '0 : bus.rsp_id + IW'(1);
                end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef LFSR_SCHED_STATS_EN
    // grant counter wraps, stall counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            if (grant)
                stat_grants <= stat_grants + 16'd1;
            if (bus.rsp_valid && !bus.rsp_ready && stat_stalls != 16'hFFFF)
                stat_stalls <= stat_stalls + 16'd1;
        end
    end
`endif

endmodule

// File: doc/lfsr_sched.md
# lfsr_sched

Round-robin scheduler that shares one 5-bit Galois LFSR among `NREQ` requesters. Each requester asks for a number of LFSR steps. The scheduler grants one request at a time, advances the LFSR that many cycles, then returns the resulting state to the granted requester over a valid/ready response channel. It sits between traffic/test-pattern clients and the LFSR datapath, and it also owns LFSR seeding.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `CW`, default 4: width of the per-request step count.

Ports:
- `clk`  in  1  Sole clock; all logic on its rising edge.
- `rst`  in  1  Synchronous, active-high reset.
- `req_valid`  in  NREQ  Request pending, one bit per requester.
- `req_steps`  in  NREQ*CW  Step counts; requester i occupies bits [i*CW +: CW].
- `req_ready`  out  NREQ  One-hot grant pulse; a request is accepted when `req_valid[i] & req_ready[i]`.
- `seed_valid`  in  1  Load a new LFSR seed.
- `seed`  in  5  Seed value.
- `seed_ready`  out  1  High in IDLE; the seed is accepted when `seed_valid & seed_ready`.
- `rsp_valid`  out  1  Response available.
- `rsp_ready`  in  1  Consumer accepts the response.
- `rsp_id`  out  $clog2(NREQ)  Index of the granted requester.
- `rsp_data`  out  5  LFSR state after the requested steps.
- `busy`  out  1  State is not IDLE.

## Operation
- LFSR update, with s as the current state: n[4]=s[0], n[3]=s[4], n[2]=s[3]^s[0], n[1]=s[2], n[0]=s[1].
- LFSR reset value is 5'h01. A seed of 0 is loaded as 5'h01, so the LFSR never locks up.
- FSM states: IDLE, STEP, RESP.
- IDLE transitions:
  - If `seed_valid`, load the seed and stay in IDLE. Seeding has priority over requests.
  - Otherwise, if any `req_valid`, grant the first requester at or after pointer `rr_ptr`, scanning upward with wrap-around.
  - On a grant: assert the `req_ready` bit combinationally and latch the id and the step count.
  - If the latched count is 0, go to RESP; otherwise go to STEP.
- STEP: the LFSR advances once per cycle and the remaining count decrements. When the remaining count is 1, the final step occurs and the next state is RESP.
- RESP:
  - `rsp_valid`=1, with `rsp_id` and `rsp_data` (the current LFSR state) held stable until `rsp_ready`.
  - On handshake: go to IDLE and set `rr_ptr` = id+1, wrapping modulo NREQ.
- Requests and seeds are not accepted outside IDLE: `req_ready`=0 and `seed_ready`=0.
- Count arithmetic is unsigned, CW bits. The maximum request is 2^CW−1 steps.
- Reset values: state IDLE, LFSR 5'h01, `rr_ptr` 0, `req_ready` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 5'h01, `busy` 0.
- `seed_ready` is 1 during reset and from the first cycle after reset, since it follows the IDLE state.

## Timing
- Request accepted in cycle t with count N≥1: STEP in cycles t+1..t+N, `rsp_valid` first high in cycle t+N+1.
- Count N=0: `rsp_valid` first high in cycle t+1, and data equals the unchanged LFSR state.
- Response handshake in cycle r: IDLE in r+1, so the earliest next grant is in r+1.
- Back-to-back throughput is one response per N+2 cycles.
- A seed accepted in cycle t is visible as the LFSR state in t+1.
- `rsp_ready` held high while `rsp_valid` is low has no effect.
- `rst` asserted in any state: all state and outputs take their reset values the next cycle, and any in-flight request is dropped without a response.

## Configuration
- Macro `LFSR_SCHED_STATS_EN`.
- When defined, two extra output ports exist:
  - `stat_grants` [15:0]: counts accepted requests, wraps at 2^16.
  - `stat_stalls` [15:0]: counts cycles with `rsp_valid & !rsp_ready`, saturates at 16'hFFFF.
  - Both counters clear on `rst`.
- When not defined, both ports and all associated logic are absent. Behaviour is otherwise identical.

## Structure
- Package `lfsr_sched_pkg` contains:
  - `LFSR_W` = 5.
  - `LFSR_RST` = 5'h01.
  - The state enum `sched_state_e`: IDLE, STEP, RESP.
  - A function `lfsr_next(logic [4:0])` implementing the update equations.
- Sub-module `lfsr_step_core`: ports `clk`, `rst`, `en`, `load`, `load_val`, `state`. It holds the 5-bit register and applies seed substitution. `load` has priority over `en`.
- The top level contains the FSM, the round-robin picker, the step counter and the optional stats.

## Test plan
- Reset, then `req_valid[0]`, steps=1, `rsp_ready`=1 → `rsp_valid` 2 cycles after accept, `rsp_id`=0, `rsp_data`=5'h14.
- From reset, `req_valid[2]`, steps=3 → `rsp_data`=5'h05, `rsp_id`=2, response 4 cycles after accept.
- All four `req_valid` high, steps=0 each, `rsp_ready`=1 → grants in order 0,1,2,3, one every 2 cycles, each `rsp_data`=5'h01.
- Seed 0 → LFSR state 5'h01. Then seed 5'h14 and a request with steps=1 → `rsp_data`=5'h0A. A seed held during STEP is not accepted until IDLE.
- `rsp_ready` held low 5 cycles in RESP → data and id stable, no `req_ready`. With `LFSR_SCHED_STATS_EN`, `stat_stalls`=5 and `stat_grants`=1.
- `rst` pulsed in the middle of a steps=10 STEP → next cycle IDLE, `busy`=0, LFSR 5'h01, no response emitted, and a new request is served from `rr_ptr` 0.
